uart_rx: RTL and testbench

UART receive stage that sits directly downstream of the 16x-oversampling baud tick generator. It synchronises the asynchronous serial line, detects and validates start bits, and samples each bit at mid-period with 3-sample majority voting. It presents each received byte with a single-cycle valid strobe and flags framing errors. It feeds the ASCII/command handling logic.

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receive stage fed by a 16x oversampling baud tick.
// The serial line is synchronised, start bits are validated, and each bit is
// taken as the majority of three mid-period samples. A good frame produces a
// one-cycle valid strobe with the byte on data. A low stop bit produces a
// one-cycle frame_err strobe instead.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(DATA_BITS) + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(OVERSAMPLE / 2);
   localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(OVERSAMPLE / 2 + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t               state, state_next;
   logic                 rx_meta, rx_s;
   logic [CNT_W-1:0]     cnt, cnt_next;
   logic [IDX_W-1:0]     bit_idx, bit_idx_next;
   logic [2:0]           samples, samples_next;
   logic [DATA_BITS-1:0] shift, shift_next;
   logic [DATA_BITS-1:0] data_next;
   logic                 valid_next, frame_err_next;
   logic                 maj_mid, maj_bit;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // START and STOP decide on the third sample tick, so the live rx_s stands
   // in for the sample that is only being captured on this edge.
   assign maj_mid = maj3(samples[0], samples[1], rx_s);
   assign maj_bit = maj3(samples[0], samples[1], samples[2]);
   assign busy    = (state != IDLE);

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // State and datapath registers, all loaded from the next-state logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         samples   <= '0;
         shift     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         bit_idx   <= bit_idx_next;
         samples   <= samples_next;
         shift     <= shift_next;
         data      <= data_next;
         valid     <= valid_next;
         frame_err <= frame_err_next;
      end
   end

   // Next-state logic: everything advances on tick except the WAIT_HIGH exit.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      bit_idx_next   = bit_idx;
      samples_next   = samples;
      shift_next     = shift;
      data_next      = data;
      valid_next     = 1'b0;
      frame_err_next = 1'b0;

      if (tick && (state == START || state == DATA || state == STOP)) begin
         if (cnt == SAMP_A) samples_next[0] = rx_s;
         if (cnt == SAMP_B) samples_next[1] = rx_s;
         if (cnt == SAMP_C) samples_next[2] = rx_s;
      end

      case (state)
         IDLE: begin
            if (tick && !rx_s) begin
               state_next = START;
               cnt_next   = CNT_W'(1);
            end
         end
         START: begin
            if (tick) begin
               cnt_next = cnt + 1'b1;
               if (cnt == SAMP_C && maj_mid) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_next   = DATA;
                  cnt_next     = '0;
                  bit_idx_next = '0;
               end
            end
         end
         DATA: begin
            if (tick) begin
               cnt_next = cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  cnt_next     = '0;
                  shift_next   = {maj_bit, shift[DATA_BITS-1:1]};
                  bit_idx_next = bit_idx + 1'b1;
                  if (bit_idx == IDX_LAST) begin
                     state_next = STOP;
                  end
               end
            end
         end
         STOP: begin
            if (tick) begin
               cnt_next = cnt + 1'b1;
               if (cnt == SAMP_C) begin
                  cnt_next = '0;
                  if (maj_mid) begin
                     data_next  = shift;
                     valid_next = 1'b1;
                     state_next = IDLE;
                  end else begin
                     frame_err_next = 1'b1;
                     state_next     = WAIT_HIGH;
                  end
               end
            end
         end
         WAIT_HIGH: begin
            if (rx_s) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames, scoreboarded strobes.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   typedef struct packed {
      logic       isErr;
      logic [7:0] value;
   } expect_t;

   expect_t expQ[$];
   expect_t monE;
   int      errors = 0;
   int      checks = 0;

   uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .tick(tick),
      .rx(rx),
      .data(data),
      .valid(valid),
      .frame_err(frame_err),
      .busy(busy)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   // One-clk tick every 4 clk, so a bit period is 64 clk.
   initial begin
      tick = 1'b0;
      forever begin
         @(negedge clk) tick = 1'b1;
         @(negedge clk) tick = 1'b0;
         repeat (2) @(negedge clk);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic expectStrobe(input logic isErr, input logic [7:0] v);
      expQ.push_back('{isErr: isErr, value: v});
   endtask

   task automatic idleClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Start bit, LSB-first data, one stop bit; optional 4-clk spike mid-bit.
   task automatic applyStimulus(input logic [7:0] b, input logic stopVal,
                                input int spikeBit);
      rx = 1'b0;
      idleClk(64);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == spikeBit) begin
            idleClk(32);
            rx = ~b[i];
            idleClk(4);
            rx = b[i];
            idleClk(28);
         end else begin
            idleClk(64);
         end
      end
      rx = stopVal;
      idleClk(64);
      rx = 1'b1;
   endtask

   // Scoreboard monitor: every strobe must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && (valid || frame_err)) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_strobe: valid=%0b frame_err=%0b data=%0h expected no strobe",
                     valid, frame_err, data);
         end else begin
            monE = expQ.pop_front();
            checkOutput("strobe_kind", {30'd0, valid, frame_err},
                        monE.isErr ? 32'd1 : 32'd2);
            checkOutput("strobe_data", {24'd0, data}, {24'd0, monE.value});
         end
      end
   end

   initial begin
      logic [7:0] partial;
      rst_n = 1'b0;
      rx    = 1'b1;
      idleClk(5);
      checkOutput("reset_data", {24'd0, data}, 32'd0);
      checkOutput("reset_valid", {31'd0, valid}, 32'd0);
      checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      idleClk(40);

      // Single good frame.
      expectStrobe(1'b0, 8'h55);
      applyStimulus(8'h55, 1'b1, -1);
      idleClk(10);
      checkOutput("t1_busy_after", {31'd0, busy}, 32'd0);
      checkOutput("t1_data_hold", {24'd0, data}, 32'h55);
      checkOutput("t1_drain", 32'(expQ.size()), 32'd0);

      // Back-to-back frames with no idle between stop and start.
      expectStrobe(1'b0, 8'hA3);
      expectStrobe(1'b0, 8'h0F);
      applyStimulus(8'hA3, 1'b1, -1);
      applyStimulus(8'h0F, 1'b1, -1);
      idleClk(20);
      checkOutput("t2_drain", 32'(expQ.size()), 32'd0);
      checkOutput("t2_data", {24'd0, data}, 32'h0F);

      // Short low glitch: 5 ticks, rejected as a false start.
      rx = 1'b0;
      idleClk(12);
      checkOutput("t3_busy_start", {31'd0, busy}, 32'd1);
      idleClk(8);
      rx = 1'b1;
      idleClk(28);
      checkOutput("t3_busy_back", {31'd0, busy}, 32'd0);
      idleClk(40);
      checkOutput("t3_data_hold", {24'd0, data}, 32'h0F);

      // Break after a frame: frame_err once, data held, waits for line high.
      expectStrobe(1'b0, 8'h11);
      applyStimulus(8'h11, 1'b1, -1);
      idleClk(64);
      expectStrobe(1'b1, 8'h11);
      applyStimulus(8'hC3, 1'b0, -1);
      rx = 1'b0;
      idleClk(32);
      checkOutput("t4_busy_break", {31'd0, busy}, 32'd1);
      checkOutput("t4_data_hold", {24'd0, data}, 32'h11);
      checkOutput("t4_drain_err", 32'(expQ.size()), 32'd0);
      rx = 1'b1;
      idleClk(8);
      checkOutput("t4_busy_release", {31'd0, busy}, 32'd0);
      idleClk(64);
      expectStrobe(1'b0, 8'h7E);
      applyStimulus(8'h7E, 1'b1, -1);
      idleClk(20);
      checkOutput("t4_data_next", {24'd0, data}, 32'h7E);

      // One-tick spike in the middle of bit 3 is outvoted.
      expectStrobe(1'b0, 8'h96);
      applyStimulus(8'h96, 1'b1, 3);
      idleClk(20);
      checkOutput("t5_drain", 32'(expQ.size()), 32'd0);
      checkOutput("t5_data", {24'd0, data}, 32'h96);

      // Reset in the middle of bit 4 of a frame.
      partial = 8'h5A;
      rx = 1'b0;
      idleClk(64);
      for (int i = 0; i < 4; i++) begin
         rx = partial[i];
         idleClk(64);
      end
      rx = partial[4];
      idleClk(32);
      rst_n = 1'b0;
      rx    = 1'b1;
      #1;
      checkOutput("t6_reset_data", {24'd0, data}, 32'd0);
      checkOutput("t6_reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("t6_reset_strobes", {30'd0, valid, frame_err}, 32'd0);
      idleClk(8);
      rst_n = 1'b1;
      idleClk(64);
      expectStrobe(1'b0, 8'h42);
      applyStimulus(8'h42, 1'b1, -1);
      idleClk(20);
      checkOutput("t6_data", {24'd0, data}, 32'h42);

      idleClk(20);
      checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
